// File: rtl/instr_fetch_pkg.sv
// Shared widths, constants and the fetch-buffer entry type for the instruction fetch front end.
package instr_fetch_pkg;

    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned INST_W      = 32;

    localparam logic [INST_W-1:0]      INST_NOP         = 32'h0000_0013;
    localparam logic [INST_ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [INST_ADDR_W-1:0] addr;
        logic [INST_W-1:0]      instr;
    } fetch_entry_t;

    function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] a);
        return {a[INST_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_if_fifo.sv
// Synchronous FIFO buffering returned fetch entries; flush takes priority over push and pop.
module if_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != FULL_CNT) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by overflow
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: PC, request issue, response buffering and the registered output stage.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
    parameter int unsigned FIFO_DEPTH      = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        if_mem_req_out,
    output logic [31:0] if_mem_addr_out,
    input  logic        if_mem_gnt_in,
    input  logic        if_mem_rvalid_in,
    input  logic [31:0] if_mem_rdata_in,
    input  logic        if_jump_en_in,
    input  logic [31:0] if_jump_addr_in,
    input  logic        if_hold_in,
    output logic [31:0] if_instr_addr_out,
    output logic [31:0] if_instr_out,
    output logic        if_instr_valid_out
);

    localparam int unsigned   CW        = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0]   DEPTH_W   = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] MAX_OUT_W = CW'(MAX_OUTSTANDING);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW:0]   drop_q, drop_d;
    logic          started_q, started_d;
    logic          valid_q, valid_d;
    logic [31:0]   instr_q, instr_d;
    logic [31:0]   instr_addr_q, instr_addr_d;

    logic          req, issue, accept, load, bypass;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  fifo_wdata, fifo_rdata;

    if_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (if_jump_en_in),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Room is reserved for every in-flight request so a response never meets a full FIFO
    always_comb begin
        req = started_q && !if_jump_en_in
              && (({1'b0, outstanding_q} + {1'b0, fifo_count}) < DEPTH_W)
              && (outstanding_q < MAX_OUT_W);
        issue      = req && if_mem_gnt_in;
        accept     = if_mem_rvalid_in && (drop_q == '0);
        load       = !valid_q || !if_hold_in;
        bypass     = load && fifo_empty && accept;
        fifo_pop   = load && !fifo_empty && !if_jump_en_in;
        fifo_push  = accept && !bypass && !fifo_full && !if_jump_en_in;
        fifo_wdata = '{addr: resp_pc_q, instr: if_mem_rdata_in};
    end

    always_comb begin
        started_d     = 1'b1;
        pc_d          = issue  ? pc_q + 32'd4 : pc_q;
        resp_pc_d     = accept ? resp_pc_q + 32'd4 : resp_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        valid_d       = valid_q;
        instr_d       = instr_q;
        instr_addr_d  = instr_addr_q;

        case ({issue, accept})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
        if (if_mem_rvalid_in && (drop_q != '0)) drop_d = drop_q - 1'b1;

        if (load) begin
            if (!fifo_empty) begin
                valid_d      = 1'b1;
                instr_d      = fifo_rdata.instr;
                instr_addr_d = fifo_rdata.addr;
            end else if (accept) begin
                valid_d      = 1'b1;
                instr_d      = if_mem_rdata_in;
                instr_addr_d = resp_pc_q;
            end else begin
                valid_d = 1'b0;
                instr_d = INST_NOP;
            end
        end

        // A response landing on the jump cycle retires the oldest in-flight request
        if (if_jump_en_in) begin
            pc_d          = word_align(if_jump_addr_in);
            resp_pc_d     = word_align(if_jump_addr_in);
            outstanding_d = '0;
            drop_d        = drop_q + (CW + 1)'(outstanding_q) - (CW + 1)'(if_mem_rvalid_in);
            valid_d       = 1'b0;
            instr_d       = INST_NOP;
            instr_addr_d  = instr_addr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_q     <= 1'b0;
            pc_q          <= word_align(RESET_PC);
            resp_pc_q     <= word_align(RESET_PC);
            outstanding_q <= '0;
            drop_q        <= '0;
            valid_q       <= 1'b0;
            instr_q       <= INST_NOP;
            instr_addr_q  <= '0;
        end else begin
            started_q     <= started_d;
            pc_q          <= pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            valid_q       <= valid_d;
            instr_q       <= instr_d;
            instr_addr_q  <= instr_addr_d;
        end
    end

    assign if_mem_req_out     = req;
    assign if_mem_addr_out    = pc_q;
    assign if_instr_addr_out  = instr_addr_q;
    assign if_instr_out       = instr_q;
    assign if_instr_valid_out = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory model, expected-instruction queue and directed scenarios.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam logic [31:0] RPC   = 32'h0000_0080;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned MAXO  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_mem_req_out;
    logic [31:0] if_mem_addr_out;
    logic        if_mem_gnt_in;
    logic        if_mem_rvalid_in;
    logic [31:0] if_mem_rdata_in;
    logic        if_jump_en_in;
    logic [31:0] if_jump_addr_in;
    logic        if_hold_in;
    logic [31:0] if_instr_addr_out;
    logic [31:0] if_instr_out;
    logic        if_instr_valid_out;

    always #5 clk = ~clk;

    instr_fetch #(
        .RESET_PC        (RPC),
        .FIFO_DEPTH      (DEPTH),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .if_mem_req_out     (if_mem_req_out),
        .if_mem_addr_out    (if_mem_addr_out),
        .if_mem_gnt_in      (if_mem_gnt_in),
        .if_mem_rvalid_in   (if_mem_rvalid_in),
        .if_mem_rdata_in    (if_mem_rdata_in),
        .if_jump_en_in      (if_jump_en_in),
        .if_jump_addr_in    (if_jump_addr_in),
        .if_hold_in         (if_hold_in),
        .if_instr_addr_out  (if_instr_addr_out),
        .if_instr_out       (if_instr_out),
        .if_instr_valid_out (if_instr_valid_out)
    );

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];
    int          last_due, cyc, lat, issues, valid_cycles, iss0, v0;
    logic [31:0] model_pc, model_last_addr, prev_req_addr, first_issue_addr;
    logic        prev_jump, prev_req_wait;
    logic        capt_armed, capt_valid, seen_zero;
    logic [31:0] capt_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic ok, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        mem_addr_q.delete();
        mem_due_q.delete();
        last_due        = -1;
        model_pc        = RPC;
        model_last_addr = 32'h0;
        prev_jump       = 1'b0;
        prev_req_wait   = 1'b0;
    endtask

    task automatic arm();
        capt_armed = 1'b1;
        capt_valid = 1'b0;
        seen_zero  = 1'b0;
    endtask

    task automatic peek();
        @(posedge clk);
        #1;
    endtask

    // One clock cycle: check registered outputs, drive inputs, then account for the coming edge
    task automatic cycle(input logic g, input logic j, input logic [31:0] ja, input logic h);
        int due;
        @(negedge clk);
        if (prev_jump) check("invalid_after_jump", !if_instr_valid_out, {31'b0, if_instr_valid_out}, 32'h0);
        if (if_instr_valid_out) begin
            valid_cycles++;
            if (capt_armed && !capt_valid) begin
                capt_valid = 1'b1;
                capt_addr  = if_instr_addr_out;
            end
            if (if_instr_addr_out == 32'h0) seen_zero = 1'b1;
            check("valid_has_expected", exp_q.size() != 0, if_instr_addr_out, 32'h0);
            if (exp_q.size() != 0) begin
                check("instr_addr", if_instr_addr_out == exp_q[0], if_instr_addr_out, exp_q[0]);
                check("instr_data", if_instr_out == mem_word(exp_q[0]), if_instr_out, mem_word(exp_q[0]));
                model_last_addr = exp_q[0];
            end
        end else begin
            check("nop_when_invalid", if_instr_out == INST_NOP, if_instr_out, INST_NOP);
            check("addr_holds_invalid", if_instr_addr_out == model_last_addr, if_instr_addr_out, model_last_addr);
        end

        if_mem_gnt_in   = g;
        if_jump_en_in   = j;
        if_jump_addr_in = ja;
        if_hold_in      = h;
        if (mem_due_q.size() != 0 && mem_due_q[0] <= cyc) begin
            if_mem_rvalid_in = 1'b1;
            if_mem_rdata_in  = mem_word(mem_addr_q[0]);
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end else begin
            if_mem_rvalid_in = 1'b0;
            if_mem_rdata_in  = 32'hBAD0_BAD0;
        end
        #1;

        if (j) check("req_low_on_jump", !if_mem_req_out, {31'b0, if_mem_req_out}, 32'h0);
        if (prev_req_wait && !j)
            check("req_held_until_gnt", if_mem_req_out && (if_mem_addr_out == prev_req_addr),
                  if_mem_addr_out, prev_req_addr);
        if (if_mem_req_out) check("fetch_addr", if_mem_addr_out == model_pc, if_mem_addr_out, model_pc);
        if (if_mem_req_out && g) begin
            if (issues == 0) first_issue_addr = if_mem_addr_out;
            due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            last_due = due;
            mem_addr_q.push_back(if_mem_addr_out);
            mem_due_q.push_back(due);
            exp_q.push_back(model_pc);
            model_pc = model_pc + 32'd4;
            issues++;
        end
        if (if_instr_valid_out && !h && !j && exp_q.size() != 0) void'(exp_q.pop_front());
        if (j) begin
            exp_q.delete();
            model_pc = {ja[31:2], 2'b00};
        end
        prev_jump     = j;
        prev_req_wait = if_mem_req_out && !g && !j;
        prev_req_addr = if_mem_addr_out;
        cyc++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, !if_instr_valid_out, {31'b0, if_instr_valid_out}, 32'h0);
        check({tag, "_instr"}, if_instr_out == 32'h0000_0013, if_instr_out, 32'h0000_0013);
        check({tag, "_instr_addr"}, if_instr_addr_out == 32'h0, if_instr_addr_out, 32'h0);
        check({tag, "_req"}, !if_mem_req_out, {31'b0, if_mem_req_out}, 32'h0);
        check({tag, "_mem_addr"}, if_mem_addr_out == 32'h80, if_mem_addr_out, 32'h80);
    endtask

    initial begin
        rst_n = 1'b0;
        if_mem_gnt_in = 1'b0; if_mem_rvalid_in = 1'b0; if_mem_rdata_in = '0;
        if_jump_en_in = 1'b0; if_jump_addr_in = '0; if_hold_in = 1'b0;
        cyc = 0; lat = 1; issues = 0; valid_cycles = 0;
        capt_armed = 1'b0; capt_valid = 1'b0; seen_zero = 1'b0; capt_addr = '0;
        first_issue_addr = '0;
        model_reset();

        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming, gnt always high, one-cycle response latency
        arm();
        repeat (4) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        check("first_req_addr", first_issue_addr == 32'h80, first_issue_addr, 32'h80);
        check("first_valid_addr", capt_valid && capt_addr == 32'h80, capt_addr, 32'h80);
        check("fill_latency", valid_cycles == 2, valid_cycles, 2);
        peek();
        check("hold_start_addr", if_instr_valid_out && if_instr_addr_out == 32'h88, if_instr_addr_out, 32'h88);

        // Hold for four cycles at 0x88
        iss0 = issues;
        repeat (4) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        check("hold_issue_bound", (issues - iss0) <= DEPTH, issues - iss0, DEPTH);
        peek();
        check("hold_frozen", if_instr_valid_out && if_instr_addr_out == 32'h88, if_instr_addr_out, 32'h88);
        v0 = valid_cycles;
        repeat (8) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        check("stream_continuous", (valid_cycles - v0) == 8, valid_cycles - v0, 8);

        // Build two outstanding requests, then jump
        lat = 3;
        repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        check("two_outstanding", mem_addr_q.size() == 2, mem_addr_q.size(), 2);
        cycle(1'b1, 1'b1, 32'h0000_0200, 1'b0);
        arm();
        lat = 1;
        repeat (8) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        check("jump_first_valid", capt_valid && capt_addr == 32'h200, capt_addr, 32'h200);

        // Unaligned jump near the top of the address space; PC wraps to zero
        cycle(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
        arm();
        repeat (6) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        check("jump_aligned", capt_valid && capt_addr == 32'hFFFF_FFFC, capt_addr, 32'hFFFF_FFFC);
        check("pc_wrap", seen_zero, {31'b0, seen_zero}, 32'h1);

        // Backpressure: no grants for five cycles
        repeat (5) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        peek();
        check("backpressure_drained", !if_instr_valid_out && if_instr_out == 32'h13, if_instr_out, 32'h13);
        check("backpressure_req", if_mem_req_out && if_mem_addr_out == model_pc, if_mem_addr_out, model_pc);
        repeat (5) cycle(1'b1, 1'b0, 32'h0, 1'b0);

        // Asynchronous reset between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        if_mem_gnt_in = 1'b0; if_mem_rvalid_in = 1'b0; if_jump_en_in = 1'b0; if_hold_in = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        arm();
        repeat (6) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        check("refetch_after_reset", capt_valid && capt_addr == 32'h80, capt_addr, 32'h80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
